// File: rtl/ard_bus_sched_pkg.sv
// Shared types for the Arduino link scheduler: bus command encoding, FSM states
// and grant helpers.
package ard_bus_sched_pkg;

  localparam int BUS_BYTES = 2;
  localparam int WORD_W    = BUS_BYTES * 8;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_FETCH = 2'b01,
    CMD_LOAD  = 2'b10,
    CMD_STORE = 2'b11
  } bus_cmd_t;

  typedef enum logic [3:0] {
    IDLE, WAIT_RR, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO,
    WAIT_DR, RD_HI, RD_LO, DONE, ERR
  } sched_state_t;

  // Fixed priority: store beats load beats fetch.
  function automatic bus_cmd_t pick_cmd(input logic store, input logic load, input logic fetch);
    if (store)      return CMD_STORE;
    else if (load)  return CMD_LOAD;
    else if (fetch) return CMD_FETCH;
    return CMD_NONE;
  endfunction

  function automatic logic [2:0] grant_of(input bus_cmd_t c);
    case (c)
      CMD_STORE: return 3'b100;
      CMD_LOAD:  return 3'b010;
      CMD_FETCH: return 3'b001;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ard_bus_sched_if.sv
// Byte-wide link between the scheduler (master) and the Arduino-side shifters (slave).
interface ard_bus_sched_if;
  import ard_bus_sched_pkg::*;

  logic       ard_receive_ready;
  logic       ard_data_ready;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_out_valid;
  bus_cmd_t   cmd;

  modport master (
    input  ard_receive_ready, ard_data_ready, bus_in,
    output bus_out, bus_out_valid, cmd
  );

  modport slave (
    output ard_receive_ready, ard_data_ready, bus_in,
    input  bus_out, bus_out_valid, cmd
  );
endinterface

// File: rtl/ard_bus_sched_timeout_ctr.sv
// Handshake watchdog: counts enabled cycles and flags the cycle on which the
// count has reached TIMEOUT.
module timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             W     = $clog2(TIMEOUT + 2);
  localparam logic [W-1:0]   LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/ard_bus_sched.sv
// Arbitrates fetch/load/store over the shared byte link, sequences address,
// data and read bytes, and retries a stalled handshake up to MAX_RETRY times.
module ard_bus_sched
  import ard_bus_sched_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_fetch,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [WORD_W-1:0] fetch_addr,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] store_data,
  output logic [2:0]        gnt,
  output logic              done_fetch,
  output logic              done_load,
  output logic              done_store,
  output logic [WORD_W-1:0] rdata,
  output logic              error,
  input  logic              err_clr,
  ard_bus_sched_if.master   link
);

  localparam int           RW    = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  sched_state_t      state;
  bus_cmd_t          cmd_q;
  bus_cmd_t          winner;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic [7:0]        bus_out_q;
  logic              bus_out_valid_q;
  logic [RW-1:0]     retry_cnt;
  logic              waiting;
  logic              handshake;
  logic              expired;

  assign winner    = pick_cmd(req_store, req_load, req_fetch);
  assign waiting   = (state == WAIT_RR) || (state == WAIT_DR);
  assign handshake = (state == WAIT_RR) ? link.ard_receive_ready : link.ard_data_ready;

  // Cleared outside the wait states and on expiry, so every (re)entry starts at zero.
  timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting || expired),
    .enable  (waiting),
    .expired (expired)
  );

  assign link.bus_out       = bus_out_q;
  assign link.bus_out_valid = bus_out_valid_q;
  assign link.cmd           = cmd_q;

  // Outputs are loaded on the transition into the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cmd_q           <= CMD_NONE;
      gnt             <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      rdata           <= '0;
      bus_out_q       <= '0;
      bus_out_valid_q <= 1'b0;
      done_fetch      <= 1'b0;
      done_load       <= 1'b0;
      done_store      <= 1'b0;
      error           <= 1'b0;
      retry_cnt       <= '0;
    end else begin
      bus_out_valid_q <= 1'b0;
      done_fetch      <= 1'b0;
      done_load       <= 1'b0;
      done_store      <= 1'b0;
      case (state)
        IDLE: begin
          retry_cnt <= '0;
          if (winner != CMD_NONE) begin
            cmd_q  <= winner;
            gnt    <= grant_of(winner);
            addr_q <= (winner == CMD_FETCH) ? fetch_addr : mem_addr;
            data_q <= store_data;
            state  <= WAIT_RR;
          end
        end
        WAIT_RR, WAIT_DR: begin
          if (handshake) begin
            if (state == WAIT_RR) begin
              state           <= ADDR_HI;
              bus_out_q       <= addr_q[15:8];
              bus_out_valid_q <= 1'b1;
            end else begin
              state <= RD_HI;
            end
          end else if (expired) begin
            if (retry_cnt < MAX_R) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= WAIT_RR;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        ADDR_HI: begin
          state           <= ADDR_LO;
          bus_out_q       <= addr_q[7:0];
          bus_out_valid_q <= 1'b1;
        end
        ADDR_LO: begin
          if (cmd_q == CMD_STORE) begin
            state           <= DATA_HI;
            bus_out_q       <= data_q[15:8];
            bus_out_valid_q <= 1'b1;
          end else begin
            state <= WAIT_DR;
          end
        end
        DATA_HI: begin
          state           <= DATA_LO;
          bus_out_q       <= data_q[7:0];
          bus_out_valid_q <= 1'b1;
        end
        DATA_LO: begin
          state      <= DONE;
          done_store <= 1'b1;
        end
        RD_HI: begin
          rdata[15:8] <= link.bus_in;
          state       <= RD_LO;
        end
        RD_LO: begin
          rdata[7:0] <= link.bus_in;
          state      <= DONE;
          done_fetch <= (cmd_q == CMD_FETCH);
          done_load  <= (cmd_q == CMD_LOAD);
        end
        DONE: begin
          state     <= IDLE;
          gnt       <= '0;
          cmd_q     <= CMD_NONE;
          retry_cnt <= '0;
        end
        ERR: begin
          if (err_clr) begin
            state     <= IDLE;
            error     <= 1'b0;
            gnt       <= '0;
            cmd_q     <= CMD_NONE;
            retry_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ard_bus_sched.sv
// Directed bench for ard_bus_sched built with TIMEOUT=4, MAX_RETRY=1 so the
// retry and error paths are reachable in a handful of cycles.
module tb_ard_bus_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_fetch, req_load, req_store;
  logic [15:0] fetch_addr, mem_addr, store_data;
  logic [2:0]  gnt;
  logic        done_fetch, done_load, done_store;
  logic [15:0] rdata;
  logic        error;
  logic        err_clr;

  int compared   = 0;
  int mismatched = 0;

  ard_bus_sched_if link();

  ard_bus_sched #(.TIMEOUT(4), .MAX_RETRY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_fetch  (req_fetch),
    .req_load   (req_load),
    .req_store  (req_store),
    .fetch_addr (fetch_addr),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .gnt        (gnt),
    .done_fetch (done_fetch),
    .done_load  (done_load),
    .done_store (done_store),
    .rdata      (rdata),
    .error      (error),
    .err_clr    (err_clr),
    .link       (link)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b1;
    req_fetch = 1'b0; req_load = 1'b0; req_store = 1'b0; err_clr = 1'b0;
    fetch_addr = '0; mem_addr = '0; store_data = '0;
    link.ard_receive_ready = 1'b0; link.ard_data_ready = 1'b0; link.bus_in = '0;
    repeat (2) @(negedge clk);
    compared++;
    if ({gnt, done_fetch, done_load, done_store} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_gnt_done: got %b, required 000000", {gnt, done_fetch, done_load, done_store});
    end
    compared++;
    if (rdata !== 16'h0000 || error !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_rdata_error: got %h/%b, required 0000/0", rdata, error);
    end
    compared++;
    if ({link.bus_out_valid, link.bus_out, link.cmd} !== 11'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_link: got valid=%b bus=%h cmd=%b, required 0/00/00",
               link.bus_out_valid, link.bus_out, link.cmd);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    link.ard_receive_ready = 1'b1; link.ard_data_ready = 1'b1; link.bus_in = 8'hA5;
    fetch_addr = 16'h1234; req_fetch = 1'b1;
    @(negedge clk);
    compared++;
    if (gnt !== 3'b001 || link.cmd !== 2'b01 || link.bus_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fetch_grant: got gnt=%b cmd=%b valid=%b, required 001/01/0", gnt, link.cmd, link.bus_out_valid);
    end
    @(negedge clk);
    compared++;
    if ({link.bus_out_valid, link.bus_out, link.cmd} !== {1'b1, 8'h12, 2'b01}) begin
      mismatched++;
      $display("[TB] FAIL fetch_addr_hi: got valid=%b bus=%h cmd=%b, required 1/12/01", link.bus_out_valid, link.bus_out, link.cmd);
    end
    @(negedge clk);
    compared++;
    if ({link.bus_out_valid, link.bus_out, link.cmd} !== {1'b1, 8'h34, 2'b01}) begin
      mismatched++;
      $display("[TB] FAIL fetch_addr_lo: got valid=%b bus=%h cmd=%b, required 1/34/01", link.bus_out_valid, link.bus_out, link.cmd);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (done_fetch !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL fetch_early_done: got %b, required 0", done_fetch);
    end
    link.bus_in = 8'h5A;
    @(negedge clk);
    compared++;
    if (done_fetch !== 1'b1 || done_load !== 1'b0 || done_store !== 1'b0 || rdata !== 16'hA55A) begin
      mismatched++;
      $display("[TB] FAIL fetch_done: got done=%b%b%b rdata=%h, required 001/a55a", done_store, done_load, done_fetch, rdata);
    end
    req_fetch = 1'b0;
    @(negedge clk);
    compared++;
    if (done_fetch !== 1'b0 || gnt !== 3'b000 || rdata !== 16'hA55A) begin
      mismatched++;
      $display("[TB] FAIL fetch_after_done: got done=%b gnt=%b rdata=%h, required 0/000/a55a", done_fetch, gnt, rdata);
    end
  endtask

  task automatic test_store();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'h00, 8'hF0, 8'hBE, 8'hEF};
    @(negedge clk);
    link.ard_receive_ready = 1'b1; link.ard_data_ready = 1'b0;
    mem_addr = 16'h00F0; store_data = 16'hBEEF; req_store = 1'b1;
    @(negedge clk);
    compared++;
    if (gnt !== 3'b100 || link.cmd !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL store_grant: got gnt=%b cmd=%b, required 100/11", gnt, link.cmd);
    end
    // Operands must already be latched; the request is also dropped mid-flight.
    mem_addr = 16'hFFFF; store_data = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) req_store = 1'b0;
      compared++;
      if ({link.bus_out_valid, link.bus_out, link.cmd} !== {1'b1, exp_bytes[i], 2'b11}) begin
        mismatched++;
        $display("[TB] FAIL store_byte%0d: got valid=%b bus=%h cmd=%b, required 1/%h/11",
                 i, link.bus_out_valid, link.bus_out, link.cmd, exp_bytes[i]);
      end
    end
    @(negedge clk);
    compared++;
    if (done_store !== 1'b1 || gnt !== 3'b100 || link.bus_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL store_done: got done=%b gnt=%b valid=%b, required 1/100/0", done_store, gnt, link.bus_out_valid);
    end
    @(negedge clk);
    compared++;
    if (done_store !== 1'b0 || gnt !== 3'b000 || link.cmd !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL store_idle: got done=%b gnt=%b cmd=%b, required 0/000/00", done_store, gnt, link.cmd);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_gnt [3];
    int         exp_done [3];
    int         cycles;
    logic       seen;
    logic [2:0] dones;
    exp_gnt  = '{3'b100, 3'b010, 3'b001};
    exp_done = '{6, 7, 7};
    @(negedge clk);
    link.ard_receive_ready = 1'b1; link.ard_data_ready = 1'b1; link.bus_in = 8'h3C;
    mem_addr = 16'h4000; fetch_addr = 16'h0100; store_data = 16'h1111;
    req_store = 1'b1; req_load = 1'b1; req_fetch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      if (gnt !== exp_gnt[k]) begin
        mismatched++;
        $display("[TB] FAIL b2b_grant%0d: got %b, required %b", k, gnt, exp_gnt[k]);
      end
      cycles = 1;
      seen   = 1'b0;
      dones  = 3'b000;
      while (!seen && cycles < 20) begin
        @(negedge clk);
        cycles++;
        dones = {done_store, done_load, done_fetch};
        if (dones != 3'b000) seen = 1'b1;
      end
      compared++;
      if (!seen || dones !== exp_gnt[k] || cycles != exp_done[k]) begin
        mismatched++;
        $display("[TB] FAIL b2b_done%0d: got done=%b at cycle %0d (seen=%b), required %b at cycle %0d",
                 k, dones, cycles, seen, exp_gnt[k], exp_done[k]);
      end
      if (k > 0) begin
        compared++;
        if (rdata !== 16'h3C3C) begin
          mismatched++;
          $display("[TB] FAIL b2b_rdata%0d: got %h, required 3c3c", k, rdata);
        end
      end
      case (k)
        0: req_store = 1'b0;
        1: req_load  = 1'b0;
        default: req_fetch = 1'b0;
      endcase
      @(negedge clk);
      compared++;
      if (gnt !== 3'b000 || {done_store, done_load, done_fetch} !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL b2b_idle%0d: got gnt=%b done=%b, required 000/000", k, gnt, {done_store, done_load, done_fetch});
      end
    end
  endtask

  task automatic test_retry_error();
    logic [7:0]  sent [$];
    logic [31:0] got_bytes;
    int          err_cycle;
    int          done_seen;
    err_cycle = 0;
    done_seen = 0;
    got_bytes = '0;
    @(negedge clk);
    link.ard_receive_ready = 1'b1; link.ard_data_ready = 1'b0;
    mem_addr = 16'hCAFE; req_load = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (link.bus_out_valid) sent.push_back(link.bus_out);
      if (done_load) done_seen++;
      if (error && err_cycle == 0) err_cycle = c;
      err_clr = (c == 1);
    end
    for (int i = 0; i < sent.size() && i < 4; i++) got_bytes = {got_bytes[23:0], sent[i]};
    compared++;
    if (sent.size() != 4 || got_bytes !== 32'hCAFECAFE) begin
      mismatched++;
      $display("[TB] FAIL retry_bytes: got %0d bytes starting %h, required 4 bytes cafecafe", sent.size(), got_bytes);
    end
    compared++;
    if (err_cycle != 17) begin
      mismatched++;
      $display("[TB] FAIL retry_err_cycle: got error at cycle %0d, required 17", err_cycle);
    end
    compared++;
    if (done_seen != 0 || gnt !== 3'b010 || error !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL retry_err_hold: got done_count=%0d gnt=%b error=%b, required 0/010/1", done_seen, gnt, error);
    end
    req_load = 1'b0;
    err_clr  = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    compared++;
    if (error !== 1'b0 || gnt !== 3'b000 || link.cmd !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL err_clr: got error=%b gnt=%b cmd=%b, required 0/000/00", error, gnt, link.cmd);
    end
  endtask

  task automatic test_timeout_edge();
    int          valid_count;
    int          done_cycle;
    logic [15:0] got_rdata;
    valid_count = 0;
    done_cycle  = 0;
    got_rdata   = '0;
    @(negedge clk);
    link.ard_receive_ready = 1'b1; link.ard_data_ready = 1'b0; link.bus_in = 8'h77;
    mem_addr = 16'h0102; req_load = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (link.bus_out_valid) valid_count++;
      if (done_load && done_cycle == 0) begin
        done_cycle = c;
        got_rdata  = rdata;
        req_load   = 1'b0;
      end
      if (c == 8)  link.ard_data_ready = 1'b1;
      if (c == 10) link.bus_in = 8'h88;
    end
    link.ard_data_ready = 1'b0;
    compared++;
    if (valid_count != 2) begin
      mismatched++;
      $display("[TB] FAIL edge_no_retry: got %0d bytes sent, required 2", valid_count);
    end
    compared++;
    if (done_cycle != 11 || got_rdata !== 16'h7788) begin
      mismatched++;
      $display("[TB] FAIL edge_done: got done at cycle %0d rdata=%h, required cycle 11 rdata 7788", done_cycle, got_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got_bytes;
    int          done_cycle;
    got_bytes  = '0;
    done_cycle = 0;
    @(negedge clk);
    link.ard_receive_ready = 1'b1; link.ard_data_ready = 1'b0;
    mem_addr = 16'h0A0B; store_data = 16'hC0DE; req_store = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if ({link.bus_out_valid, link.bus_out} !== {1'b1, 8'hC0}) begin
      mismatched++;
      $display("[TB] FAIL rstmid_data_hi: got valid=%b bus=%h, required 1/c0", link.bus_out_valid, link.bus_out);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({gnt, done_store, link.bus_out_valid, link.bus_out, link.cmd, error, rdata} !== 32'b0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_async: got gnt=%b done=%b valid=%b bus=%h cmd=%b error=%b rdata=%h, required all zero",
               gnt, done_store, link.bus_out_valid, link.bus_out, link.cmd, error, rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (gnt !== 3'b100 || link.cmd !== 2'b11 || link.bus_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rstmid_restart: got gnt=%b cmd=%b valid=%b, required 100/11/0", gnt, link.cmd, link.bus_out_valid);
    end
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (link.bus_out_valid) got_bytes = {got_bytes[23:0], link.bus_out};
      if (done_store && done_cycle == 0) begin
        done_cycle = c;
        req_store  = 1'b0;
      end
    end
    compared++;
    if (got_bytes !== 32'h0A0BC0DE || done_cycle != 6) begin
      mismatched++;
      $display("[TB] FAIL rstmid_complete: got bytes %h done at cycle %0d, required 0a0bc0de at cycle 6", got_bytes, done_cycle);
    end
  endtask

  initial begin
    $display("[TB] ard_bus_sched directed tests starting");
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_retry_error();
    test_timeout_edge();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
